// File: rtl/alu_pipe.sv
// alu_pipe: single-cycle ALU with an iterative shift-add multiply and a valid/ready result slot.
// Results and flags are registered together; a consumed slot can be refilled on the same edge.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_v,
    output logic [4:0]       o_flags
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t             state_q, state_d;
    logic               en_q;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   v_q, v_d;
    logic [4:0]         flags_q, flags_d;
    logic [2*WIDTH-1:0] mc_q, mc_d, acc_q, acc_d;
    logic [WIDTH-1:0]   mp_q, mp_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_v;
    logic [4:0]         alu_f;
    logic               alu_c, alu_ovf, is_mul, accept;

    assign o_ready = en_q && (state_q == IDLE) && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready;
    assign is_mul  = (i_op == 4'd8) && (MUL_EN != 0);
    assign o_valid = valid_q;
    assign o_v     = v_q;
    assign o_flags = flags_q;

    always_comb begin
        sum     = {1'b0, i_a} + {1'b0, i_b};
        diff    = {1'b0, i_a} - {1'b0, i_b};
        alu_v   = '0;
        alu_c   = 1'b0;
        alu_ovf = 1'b0;
        case (i_op)
            4'd0: begin
                alu_v   = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            4'd1: begin
                alu_v   = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            4'd2: alu_v = ~(i_a & i_b);
            4'd3: alu_v = i_a ^ i_b;
            4'd4: alu_v = i_a | i_b;
            // Shift amounts >= WIDTH fall out of the language semantics: zero fill, or sign fill for >>>
            4'd5: alu_v = i_a << i_b;
            4'd6: alu_v = i_a >> i_b;
            4'd7: alu_v = $signed(i_a) >>> i_b;
            default: alu_v = '0;
        endcase
        alu_f = (i_op < 4'd8) ? {1'b0, alu_ovf, alu_c, alu_v[WIDTH-1], alu_v == '0} : 5'b10000;
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q && !i_ready;
        v_d     = v_q;
        flags_d = flags_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (accept && is_mul) begin
            state_d = MUL;
            mc_d    = {{WIDTH{1'b0}}, i_a};
            mp_d    = i_b;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            v_d     = alu_v;
            flags_d = alu_f;
        end
        if (state_q == MUL) begin
            acc_d   = mp_q[0] ? acc_q + mc_q : acc_q;
            mc_d    = mc_q << 1;
            mp_d    = mp_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(WIDTH - 1)) ? HOLD : MUL;
        end
        if (state_q == HOLD) begin
            state_d = IDLE;
            valid_d = 1'b1;
            v_d     = acc_q[WIDTH-1:0];
            flags_d = {2'b00, |acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1], acc_q[WIDTH-1:0] == '0};
        end
    end

    // en_q keeps o_ready low until the first edge after reset release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            v_q     <= '0;
            flags_q <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
            valid_q <= valid_d;
            v_q     <= v_d;
            flags_q <= flags_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe (WIDTH=8) plus a MUL_EN=0 instance for the illegal-multiply case.
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst_n, valid, ready, valid2;
    logic [7:0] a, b;
    logic [3:0] op, op2;
    logic       o_ready, o_valid, o_ready2, o_valid2;
    logic [7:0] o_v, o_v2;
    logic [4:0] o_flags, o_flags2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
        .i_a(a), .i_b(b), .i_op(op), .o_valid(o_valid), .i_ready(ready),
        .o_v(o_v), .o_flags(o_flags)
    );

    alu_pipe #(.WIDTH(8), .MUL_EN(0)) dut_nomul (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .o_ready(o_ready2),
        .i_a(a), .i_b(b), .i_op(op2), .o_valid(o_valid2), .i_ready(ready),
        .o_v(o_v2), .o_flags(o_flags2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input string tag, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] ev, input logic [4:0] ef);
        valid = 1'b1; op = o; a = x; b = y;
        tick();
        valid = 1'b0;
        chk({tag, "_valid"}, o_valid, 1);
        chk({tag, "_v"}, o_v, ev);
        chk({tag, "_flags"}, o_flags, ef);
    endtask

    task automatic mul(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] ev, input logic [4:0] ef);
        int lat, low;
        valid = 1'b1; op = 4'd8; a = x; b = y;
        tick();
        valid = 1'b0; a = 8'h5A; b = 8'hC3;
        lat = 0; low = 0;
        while (!o_valid && lat < 20) begin
            if (!o_ready) low++;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_ready_low"}, low, 9);
        chk({tag, "_v"}, o_v, ev);
        chk({tag, "_flags"}, o_flags, ef);
        tick();
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; valid = 1'b0; valid2 = 1'b0; ready = 1'b1;
        a = '0; b = '0; op = '0; op2 = '0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_v", o_v, 0);
        chk("rst_flags", o_flags, 0);
        #21;
        rst_n = 1'b1;
        valid = 1'b1; op = 4'd0; a = 8'hFF; b = 8'h01;
        tick();
        chk("release_no_accept", o_valid, 0);
        chk("release_ready", o_ready, 1);
        tick();
        valid = 1'b0;
        chk("add_wrap_valid", o_valid, 1);
        chk("add_wrap_v", o_v, 8'h00);
        chk("add_wrap_flags", o_flags, 5'b00101);

        alu("add_ovf", 4'd0, 8'h7F, 8'h01, 8'h80, 5'b01010);
        alu("sub_borrow", 4'd1, 8'h03, 8'h05, 8'hFE, 5'b00110);
        alu("sub_ovf", 4'd1, 8'h80, 8'h01, 8'h7F, 5'b01000);
        alu("nand", 4'd2, 8'hF0, 8'h3C, 8'hCF, 5'b00010);
        alu("xor", 4'd3, 8'hAA, 8'hAA, 8'h00, 5'b00001);
        alu("or", 4'd4, 8'h12, 8'h21, 8'h33, 5'b00000);
        alu("shl1", 4'd5, 8'h81, 8'h01, 8'h02, 5'b00000);
        alu("shl8", 4'd5, 8'h01, 8'h08, 8'h00, 5'b00001);
        alu("shr7", 4'd6, 8'h80, 8'h07, 8'h01, 5'b00000);
        alu("shr200", 4'd6, 8'hFF, 8'd200, 8'h00, 5'b00001);
        alu("sar3", 4'd7, 8'h80, 8'h03, 8'hF0, 5'b00010);
        alu("sar9_neg", 4'd7, 8'h80, 8'h09, 8'hFF, 5'b00010);
        alu("sar9_pos", 4'd7, 8'h40, 8'h09, 8'h00, 5'b00001);
        alu("ill_c", 4'hC, 8'h55, 8'h33, 8'h00, 5'b10000);
        alu("ill_f", 4'hF, 8'hFF, 8'hFF, 8'h00, 5'b10000);
        tick();
        chk("consumed", o_valid, 0);

        mul("mul_10x11", 8'h10, 8'h11, 8'h10, 5'b00100);
        mul("mul_3x4", 8'h03, 8'h04, 8'h0C, 5'b00000);
        mul("mul_ffxff", 8'hFF, 8'hFF, 8'h01, 5'b00100);

        valid = 1'b1; op = 4'd0; a = 8'h01; b = 8'h02; ready = 1'b0;
        tick();
        chk("bp_first_v", o_v, 8'h03);
        a = 8'h10; b = 8'h20;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", o_ready, 0);
            tick();
            chk("bp_valid_hold", o_valid, 1);
            chk("bp_v_hold", o_v, 8'h03);
        end
        ready = 1'b1;
        #1;
        chk("bp_ready_up", o_ready, 1);
        tick();
        valid = 1'b0;
        chk("bp_b2b_valid", o_valid, 1);
        chk("bp_b2b_v", o_v, 8'h30);
        tick();
        chk("bp_drain", o_valid, 0);

        valid = 1'b1; op = 4'd8; a = 8'h10; b = 8'h11;
        tick();
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", o_valid, 0);
        chk("abort_ready", o_ready, 0);
        chk("abort_v", o_v, 0);
        chk("abort_flags", o_flags, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        alu("post_rst_add", 4'd0, 8'h05, 8'h06, 8'h0B, 5'b00000);
        tick();

        valid2 = 1'b1; op2 = 4'd8; a = 8'h03; b = 8'h04;
        tick();
        valid2 = 1'b0;
        chk("nomul_valid", o_valid2, 1);
        chk("nomul_v", o_v2, 8'h00);
        chk("nomul_flags", o_flags2, 5'b10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 4..32.
REQ-002 Parameter MUL_EN, default 1: 1 enables the iterative multiply opcode; 0 makes opcode 4'b1000 illegal.
REQ-003 Port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port i_valid, input, 1: request valid.
REQ-006 Port o_ready, output, 1: block accepts a request this cycle.
REQ-007 Port i_a, input, WIDTH: first operand.
REQ-008 Port i_b, input, WIDTH: second operand; shift amount for shift opcodes.
REQ-009 Port i_op, input, 4: opcode.
REQ-010 Port o_valid, output, 1: result valid.
REQ-011 Port i_ready, input, 1: downstream consumes the result this cycle.
REQ-012 Port o_v, output, WIDTH: result value.
REQ-013 Port o_flags, output, 5: {illegal, overflow, carry, negative, zero}, registered with o_v.

Function
REQ-014 Accept: the block SHALL capture i_a, i_b and i_op on a rising edge where i_valid && o_ready.
REQ-015 o_ready SHALL be (state==IDLE) && (!o_valid || i_ready), so a result consumed this cycle frees the slot for a new request.
REQ-016 The FSM SHALL have the states IDLE, MUL and HOLD, with these transitions:
- IDLE -> MUL on accepting a multiply.
- Any other accepted opcode: stay IDLE; result registered.
- MUL -> HOLD after WIDTH iterations.
- HOLD -> IDLE when the result is presented.
REQ-017 Single-cycle opcodes SHALL assert o_valid on the edge of acceptance, so the result is visible 1 cycle after the request.
REQ-018 Opcodes 0..7 SHALL compute:
- 0 add: a+b
- 1 sub: a-b
- 2 nand: ~(a&b)
- 3 xor
- 4 or
- 5 shl: a<<b
- 6 shr: logical right shift
- 7 sar: arithmetic right shift of signed a
All results are truncated to WIDTH bits.
REQ-019 Shift amounts b >= WIDTH SHALL give 0 for shl and shr, and WIDTH copies of a[WIDTH-1] for sar.
REQ-020 Opcode 8 (mul, MUL_EN=1) SHALL run a shift-add of one bit per cycle and present the low WIDTH bits of the unsigned product exactly WIDTH+1 cycles after acceptance.
REQ-021 o_ready SHALL be 0 while in MUL or HOLD.
REQ-022 Opcodes 9..15, and 8 with MUL_EN=0, SHALL produce o_v=0 with illegal=1 and all other flags 0, with single-cycle latency.
REQ-023 zero SHALL be (o_v==0); negative SHALL be o_v[WIDTH-1], for all legal opcodes.
REQ-024 carry SHALL be:
- add: carry-out
- sub: borrow (a<b unsigned)
- mul: upper half of the product nonzero
- all other opcodes: 0
REQ-025 overflow SHALL be the signed two's-complement overflow for add and sub, and 0 otherwise.
REQ-026 o_valid, o_v and o_flags SHALL hold stable while o_valid && !i_ready.
REQ-027 o_valid SHALL fall on the edge where i_ready=1, unless a new request is accepted on that same edge.
REQ-028 A simultaneous consume and new accept SHALL replace the result back-to-back with o_valid staying 1, giving a throughput of 1 per cycle for single-cycle opcodes.
REQ-029 Inputs SHALL be ignored when i_valid=0 or o_ready=0; captured operands SHALL not be affected by later changes on the inputs.

Reset
REQ-030 Asserting i_rst_n=0 SHALL immediately drive state=IDLE, o_valid=0, o_v=0 and o_flags=0.
REQ-031 o_ready SHALL be 0 while in reset and 1 on the first cycle after release.
REQ-032 A reset during MUL SHALL abort the multiply with no result ever presented.
REQ-033 No request SHALL be accepted on the edge that releases reset.

Verification
REQ-034 WIDTH=8, add 8'hFF+8'h01 -> next cycle o_v=8'h00 with zero=1 and carry=1; 8'h7F+8'h01 -> o_v=8'h80 with overflow=1 and negative=1.
REQ-035 WIDTH=8, sub 8'h03-8'h05 -> o_v=8'hFE with carry=1 and negative=1; sar 8'h80 by 3 -> 8'hF0; sar 8'h80 by 9 -> 8'hFF; shl by 8 -> 8'h00.
REQ-036 WIDTH=8, mul 8'h10*8'h11:
- o_ready=0 for 9 cycles
- o_valid then rises 9 cycles after accept with o_v=8'h10 and carry=1
- 8'h03*8'h04 gives 8'h0C with carry=0
REQ-037 Backpressure: hold i_ready=0 for 5 cycles with i_valid=1 -> o_v stable, o_ready=0; raise i_ready -> the next request is accepted the same edge and o_valid stays 1.
REQ-038 Pull i_rst_n low 3 cycles into a multiply -> o_valid=0 at once; after release, one add request gives its result after 1 cycle.
REQ-039 Opcode 4'hC, and opcode 8 with MUL_EN=0 -> o_v=0 with o_flags=5'b10000 after 1 cycle.
